// File: rtl/ss_readback_best_pkg.sv
// Shared types and constants for the seven-segment readback block.
// Segment patterns are active-low, bit0 = segment a, bit6 = segment g.
package ss_readback_best_pkg;

  localparam int DIGITS = 6;
  localparam int SEG_W  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [DIGITS-1:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ss_readback_best_if.sv
// Bus bundle for the readback block: display bus and capture controls in,
// decoded value, error info and best-score register out.
interface ss_readback_best_if;
  logic [41:0] ss;
  logic        sample;
  logic        clear_best;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        valid;
  logic [2:0]  err_digit;
  logic [23:0] best;
  logic        best_valid;
  logic        new_best;

  modport master (
    output ss, sample, clear_best,
    input  busy, done, bcd, valid, err_digit, best, best_valid, new_best
  );

  modport slave (
    input  ss, sample, clear_best,
    output busy, done, bcd, valid, err_digit, best, best_valid, new_best
  );
endinterface

// File: rtl/ss_readback_best_seg_to_bcd.sv
// Combinational segment pattern to BCD decoder with invalid flag.
// SS_READBACK_BLANK_ZERO_EN: blank pattern decodes as a valid 0.
module ss_seg_to_bcd
  import ss_readback_best_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       bcd,
  output logic             invalid
);

  always_comb begin
    bcd     = 4'hF;
    invalid = 1'b0;
    case (seg)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
`ifdef SS_READBACK_BLANK_ZERO_EN
      SEG_BLANK: bcd = 4'd0;
`else
      SEG_BLANK: invalid = 1'b1;
`endif
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ss_readback_best.sv
// Captures the 42-bit display bus, decodes one digit per clock back to BCD
// and keeps the lowest valid reading. Blank handling: SS_READBACK_BLANK_ZERO_EN.
module ss_readback_best
  import ss_readback_best_pkg::*;
(
  input  logic         clk50M,
  input  logic         rst,
  ss_readback_best_if.slave bus
);

  state_t state, state_nxt;

  logic [2:0]                        idx;
  logic [DIGITS-1:0][SEG_W-1:0]      shadow;
  logic [DIGITS-1:0][3:0]            work;
  logic [DIGITS-1:0]                 mask;

  logic        busy_q, done_q, valid_q, best_valid_q, new_best_q;
  logic [23:0] bcd_q, best_q;
  logic [2:0]  err_q;

  logic [3:0]  dig_bcd;
  logic        dig_bad;

  ss_seg_to_bcd u_dec (
    .seg     (shadow[idx]),
    .bcd     (dig_bcd),
    .invalid (dig_bad)
  );

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sample) state_nxt = DECODE;
      DECODE:  if (idx == 3'd5) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      shadow       <= '0;
      work         <= '0;
      mask         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= '0;
      bcd_q        <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      new_best_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample) begin
            shadow <= bus.ss;
            idx    <= '0;
            work   <= '0;
            mask   <= '0;
            busy_q <= 1'b1;
          end
        end
        DECODE: begin
          work[idx] <= dig_bcd;
          mask[idx] <= dig_bad;
          if (idx != 3'd5) idx <= idx + 3'd1;
        end
        PUBLISH: begin
          bcd_q   <= work;
          valid_q <= ~|mask;
          err_q   <= lowest_set(mask);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          if (!bus.clear_best && ~|mask && (!best_valid_q || work < best_q)) begin
            best_q       <= work;
            best_valid_q <= 1'b1;
            new_best_q   <= 1'b1;
          end
        end
        default: ;
      endcase
      // Clearing overrides any same-cycle best update.
      if (bus.clear_best) begin
        best_q       <= '0;
        best_valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bcd        = bcd_q;
  assign bus.valid      = valid_q;
  assign bus.err_digit  = err_q;
  assign bus.best       = best_q;
  assign bus.best_valid = best_valid_q;
  assign bus.new_best   = new_best_q;

endmodule

// File: tb/tb_ss_readback_best.sv
// Scoreboard bench for ss_readback_best: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_ss_readback_best;

  logic clk50M = 1'b0;
  logic rst;

  ss_readback_best_if bus();

  ss_readback_best dut (
    .clk50M (clk50M),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 clk50M = ~clk50M;

  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30,
                         P4 = 7'h19, P5 = 7'h12, P6 = 7'h02, P7 = 7'h78,
                         P8 = 7'h00, P9 = 7'h10, PB = 7'h7F, PX = 7'h7E;

  typedef struct packed {
    logic [23:0] bcd;
    logic        valid;
    logic [2:0]  err;
    logic [23:0] best;
    logic        best_valid;
    logic        new_best;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  function automatic logic [41:0] pk(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic exp_t mk(input logic [23:0] b, input logic v, input logic [2:0] e,
                              input logic [23:0] bst, input logic bv, input logic nb);
    exp_t r;
    r.bcd = b; r.valid = v; r.err = e; r.best = bst; r.best_valid = bv; r.new_best = nb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk50M) begin : monitor
    exp_t e;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("bcd",        bus.bcd, e.bcd);
        chk("valid",      24'(bus.valid), 24'(e.valid));
        chk("err_digit",  24'(bus.err_digit), 24'(e.err));
        chk("best",       bus.best, e.best);
        chk("best_valid", 24'(bus.best_valid), 24'(e.best_valid));
        chk("new_best",   24'(bus.new_best), 24'(e.new_best));
        chk("busy_at_done", 24'(bus.busy), 24'd0);
      end
    end
  end

  // Launch a capture, scramble ss afterwards, optionally hold sample or
  // assert clear_best in the PUBLISH cycle; checks the 7-clock latency.
  task automatic capture(input logic [41:0] s, input exp_t e, input bit clr_pub, input int hold);
    int lat;
    bit seen;
    @(negedge clk50M);
    bus.ss = s;
    bus.sample = 1'b1;
    q.push_back(e);
    @(negedge clk50M);
    bus.ss = ~s;
    lat = 0;
    if (hold == 0) bus.sample = 1'b0;
    chk("busy_after_capture", 24'(bus.busy), 24'd1);
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk50M);
      lat++;
      if (lat >= hold) bus.sample = 1'b0;
      bus.clear_best = clr_pub && (lat == 6);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.clear_best = 1'b0;
    bus.sample = 1'b0;
    chk("latency", 24'(lat), 24'd7);
    @(negedge clk50M);
    chk("done_falls", 24'(bus.done), 24'd0);
    chk("new_best_falls", 24'(bus.new_best), 24'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bcd"},        bus.bcd, 24'd0);
    chk({tag, "_valid"},      24'(bus.valid), 24'd0);
    chk({tag, "_err"},        24'(bus.err_digit), 24'd0);
    chk({tag, "_best"},       bus.best, 24'd0);
    chk({tag, "_best_valid"}, 24'(bus.best_valid), 24'd0);
    chk({tag, "_busy"},       24'(bus.busy), 24'd0);
    chk({tag, "_done"},       24'(bus.done), 24'd0);
    chk({tag, "_new_best"},   24'(bus.new_best), 24'd0);
  endtask

  initial begin
    bus.ss = '0;
    bus.sample = 1'b0;
    bus.clear_best = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk50M);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk50M);

    capture(pk(P0, P0, P0, P1, P2, P3), mk(24'h000123, 1, 0, 24'h000123, 1, 1), 0, 0);
    capture(pk(P0, P0, P0, P4, P5, P6), mk(24'h000456, 1, 0, 24'h000123, 1, 0), 0, 0);
    capture(pk(P0, P0, P0, P0, P9, P9), mk(24'h000099, 1, 0, 24'h000099, 1, 1), 0, 0);
    capture(pk(P0, P0, P0, P0, P9, P9), mk(24'h000099, 1, 0, 24'h000099, 1, 0), 0, 0);
    capture(pk(P0, P0, P0, PX, P2, P3), mk(24'h000F23, 0, 2, 24'h000099, 1, 0), 0, 0);
`ifdef SS_READBACK_BLANK_ZERO_EN
    capture(pk(PB, PB, PB, P1, P2, P3), mk(24'h000123, 1, 0, 24'h000099, 1, 0), 0, 0);
`else
    capture(pk(PB, PB, PB, P1, P2, P3), mk(24'hFFF123, 0, 3, 24'h000099, 1, 0), 0, 0);
`endif

    // Reset at E3 of a capture: no publication, everything back to zero.
    @(negedge clk50M);
    bus.ss = pk(P7, P8, P0, P1, P2, P3);
    bus.sample = 1'b1;
    @(negedge clk50M);
    bus.sample = 1'b0;
    repeat (3) @(posedge clk50M);
    #1 rst = 1'b1;
    @(negedge clk50M);
    rst = 1'b0;
    @(negedge clk50M);
    check_all_zero("mid_reset");
    repeat (10) @(negedge clk50M);

    capture(pk(P0, P0, P0, P1, P2, P3), mk(24'h000123, 1, 0, 24'h000123, 1, 1), 0, 0);
    capture(pk(P0, P0, P0, P0, P5, P0), mk(24'h000050, 1, 0, 24'h000000, 0, 0), 1, 0);
    capture(pk(P0, P0, P0, P7, P8, P9), mk(24'h000789, 1, 0, 24'h000789, 1, 1), 0, 5);

    repeat (20) @(negedge clk50M);
    chk("queue_empty", 24'(q.size()), 24'd0);
    chk("done_count", 24'(done_cnt), 24'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
